// File: rtl/pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// pong_game_ctrl
//   Game-flow controller for the pong design. It conditions the five board
//   buttons and runs the game state machine. It also holds both scores and
//   the win target, and reports the winner. The ball/paddle logic supplies
//   point pulses and consumes state/serve.
//
//   Button conditioning, per button:
//     2-FF synchroniser -> stability counter -> accepted level -> press pulse
//
// Ports
//   clk                 system clock, all logic on posedge
//   rst                 synchronous active-high reset
//   btnC/U/D/L/R        raw buttons: launch, up, down, quit, reserved
//   point_p1, point_p2  1-cycle score pulses from the ball logic
//   state               MENU=0 SET=1 START=2 PLAY=3 END_POINT=4 END_GAME=5
//   score_p1, score_p2  player scores
//   target              win target
//   winner              00 none, 01 p1, 10 p2
//   serve               1-cycle pulse on the START->PLAY transition
//   led                 one-hot of state
// -----------------------------------------------------------------------------
module pong_game_ctrl #(
   parameter int DEBOUNCE_CYC = 250000,
   parameter int POINT_HOLD   = 50000000,
   parameter int SCORE_W      = 4,
   parameter int WIN_MAX      = 9,
   parameter int WIN_DEFAULT  = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               btnC,
   input  logic               btnU,
   input  logic               btnD,
   input  logic               btnL,
   input  logic               btnR,
   input  logic               point_p1,
   input  logic               point_p2,
   output logic [2:0]         state,
   output logic [SCORE_W-1:0] score_p1,
   output logic [SCORE_W-1:0] score_p2,
   output logic [SCORE_W-1:0] target,
   output logic [1:0]         winner,
   output logic               serve,
   output logic [5:0]         led
);

   typedef enum logic [2:0] {
      ST_MENU      = 3'd0,
      ST_SET       = 3'd1,
      ST_START     = 3'd2,
      ST_PLAY      = 3'd3,
      ST_END_POINT = 3'd4,
      ST_END_GAME  = 3'd5
   } state_t;

   localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
   localparam int HOLD_W = $clog2(POINT_HOLD + 1);

   // Button vector positions
   localparam int B_C = 0;
   localparam int B_U = 1;
   localparam int B_D = 2;
   localparam int B_L = 3;
   localparam int B_R = 4;

   // ---------------------------------------------------------------------------
   // Button conditioning
   // ---------------------------------------------------------------------------
   logic [4:0]      btn_raw;
   logic [4:0]      sync1, sync2, btn_level, btn_pulse;
   logic [DB_W-1:0] db_cnt [5];

   assign btn_raw = {btnR, btnL, btnD, btnU, btnC};

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1     <= '0;
         sync2     <= '0;
         btn_level <= '0;
         btn_pulse <= '0;
         // NOTE: the counter array is cleared explicitly. Stale counts after
         // reset could otherwise accept a level early.
         for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments make sync2 take the old sync1.
         // That gives two real flop stages, not one.
         sync1     <= btn_raw;
         sync2     <= sync1;
         btn_pulse <= '0;
         for (int i = 0; i < 5; i++) begin
            if (sync2[i] != btn_level[i]) begin
               if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                  btn_level[i] <= sync2[i];
                  btn_pulse[i] <= sync2[i];   // press only, release is silent
                  db_cnt[i]    <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 1'b1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   logic launch, up, down, quit_btn;
   logic btn_r_pulse_unused;   // btnR is conditioned for future use only

   assign launch             = btn_pulse[B_C];
   assign up                 = btn_pulse[B_U];
   assign down               = btn_pulse[B_D];
   assign quit_btn           = btn_pulse[B_L];
   assign btn_r_pulse_unused = btn_pulse[B_R];

   // ---------------------------------------------------------------------------
   // Game FSM
   // ---------------------------------------------------------------------------
   state_t            cur_state, next_state;
   logic [HOLD_W-1:0] hold_cnt;
   logic              hold_done, quit;

   assign hold_done = (cur_state == ST_END_POINT) &&
                      (hold_cnt == HOLD_W'(POINT_HOLD - 1));
   assign quit      = quit_btn && (cur_state inside
                      {ST_SET, ST_START, ST_PLAY, ST_END_POINT, ST_END_GAME});

   // State register
   always_ff @(posedge clk) begin
      if (rst) cur_state <= ST_MENU;
      else     cur_state <= next_state;
   end

   // Next-state logic
   always_comb begin
      // NOTE: the default assignment first keeps this block combinational.
      // Without it, paths that do not assign next_state would infer a latch.
      next_state = cur_state;
      if (quit) begin
         next_state = ST_MENU;
      end else begin
         case (cur_state)
            ST_MENU:      if (launch) next_state = ST_SET;
            ST_SET:       if (launch) next_state = ST_START;
            ST_START:     if (launch) next_state = ST_PLAY;
            ST_PLAY:      if (point_p1 || point_p2) next_state = ST_END_POINT;
            ST_END_POINT: if (hold_done) begin
                             if (score_p1 >= target || score_p2 >= target)
                                next_state = ST_END_GAME;
                             else
                                next_state = ST_START;
                          end
            ST_END_GAME:  if (launch) next_state = ST_MENU;
            default:      next_state = ST_MENU;   // encodings 6 and 7
         endcase
      end
   end

   // Output decode
   always_comb begin
      led = 6'b000000;
      if (cur_state <= ST_END_GAME) led = 6'b000001 << cur_state;
   end

   assign state = cur_state;

   // ---------------------------------------------------------------------------
   // Point-hold timer and score/target/winner datapath
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst || cur_state != ST_END_POINT || hold_done) hold_cnt <= '0;
      else                                               hold_cnt <= hold_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         score_p1 <= '0;
         score_p2 <= '0;
         target   <= SCORE_W'(WIN_DEFAULT);
         winner   <= 2'b00;
         serve    <= 1'b0;
      end else begin
         serve <= (cur_state == ST_START) && (next_state == ST_PLAY);
         if (quit) begin
            score_p1 <= '0;
            score_p2 <= '0;
            winner   <= 2'b00;
         end else begin
            case (cur_state)
               ST_MENU: if (launch) target <= SCORE_W'(WIN_DEFAULT);
               ST_SET: begin
                  if (up && !down && target != SCORE_W'(WIN_MAX))
                     target <= target + 1'b1;
                  if (down && !up && target > SCORE_W'(1))
                     target <= target - 1'b1;
                  if (launch) begin
                     score_p1 <= '0;
                     score_p2 <= '0;
                     winner   <= 2'b00;
                  end
               end
               ST_PLAY: begin
                  // A simultaneous point is a replay, so neither score moves
                  if (point_p1 && !point_p2) score_p1 <= score_p1 + 1'b1;
                  if (point_p2 && !point_p1) score_p2 <= score_p2 + 1'b1;
               end
               ST_END_POINT: if (hold_done) begin
                  if (score_p1 >= target)      winner <= 2'b01;
                  else if (score_p2 >= target) winner <= 2'b10;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pong_game_ctrl.sv
module tb_pong_game_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btnC = 0, btnU = 0, btnD = 0, btnL = 0, btnR = 0;
   logic       point_p1 = 0, point_p2 = 0;
   logic [2:0] state;
   logic [3:0] score_p1, score_p2, target;
   logic [1:0] winner;
   logic       serve;
   logic [5:0] led;

   int n_vec = 0;
   int n_err = 0;
   int serve_cnt = 0;

   pong_game_ctrl #(
      .DEBOUNCE_CYC(4), .POINT_HOLD(8), .SCORE_W(4), .WIN_MAX(9), .WIN_DEFAULT(3)
   ) dut (
      .clk(clk), .rst(rst),
      .btnC(btnC), .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR),
      .point_p1(point_p1), .point_p2(point_p2),
      .state(state), .score_p1(score_p1), .score_p2(score_p2),
      .target(target), .winner(winner), .serve(serve), .led(led)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (serve) serve_cnt++;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Hold the buttons long enough to be accepted, then release fully
   task automatic press(input logic [4:0] b);
      {btnR, btnL, btnD, btnU, btnC} = b;
      tick(12);
      {btnR, btnL, btnD, btnU, btnC} = 5'b0;
      tick(12);
   endtask

   task automatic point(input logic p1, input logic p2);
      point_p1 = p1;
      point_p2 = p2;
      tick(1);
      point_p1 = 0;
      point_p2 = 0;
   endtask

   localparam logic [4:0] P_C = 5'b00001, P_U = 5'b00010, P_D = 5'b00100,
                          P_UD = 5'b00110, P_L = 5'b01000;

   task automatic test_reset;
      rst = 1;
      tick(3);
      rst = 0;
      n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
      n_vec++; if (target !== 4'd3) begin n_err++; $display("FAIL reset_target: got %0d want 3", target); end
      n_vec++; if ({score_p1, score_p2, winner, serve} !== 11'd0) begin n_err++;
         $display("FAIL reset_regs: got p1=%0d p2=%0d w=%0d s=%0d want all 0", score_p1, score_p2, winner, serve); end
      n_vec++; if (led !== 6'b000001) begin n_err++; $display("FAIL reset_led: got %b want 000001", led); end
   endtask

   task automatic test_bounce;
      for (int i = 0; i < 20; i++) begin
         btnC = ((i / 2) % 2 == 0);
         tick(1);
      end
      tick(8);
      n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL bounce_reject: got %0d want 0", state); end
      btnC = 1;
      tick(12);
      n_vec++; if (state !== 3'd1) begin n_err++; $display("FAIL bounce_accept: got %0d want 1", state); end
      btnC = 0;
      tick(12);
      n_vec++; if (state !== 3'd1) begin n_err++; $display("FAIL bounce_single: got %0d want 1", state); end
      n_vec++; if (led !== 6'b000010) begin n_err++; $display("FAIL set_led: got %b want 000010", led); end
   endtask

   task automatic test_target;
      n_vec++; if (target !== 4'd3) begin n_err++; $display("FAIL set_entry_target: got %0d want 3", target); end
      press(P_U);
      n_vec++; if (target !== 4'd4) begin n_err++; $display("FAIL target_up1: got %0d want 4", target); end
      for (int i = 0; i < 7; i++) press(P_U);
      n_vec++; if (target !== 4'd9) begin n_err++; $display("FAIL target_sat_hi: got %0d want 9", target); end
      for (int i = 0; i < 12; i++) press(P_D);
      n_vec++; if (target !== 4'd1) begin n_err++; $display("FAIL target_sat_lo: got %0d want 1", target); end
      press(P_U);
      press(P_UD);
      n_vec++; if (target !== 4'd2) begin n_err++; $display("FAIL target_up_down: got %0d want 2", target); end
      press(P_L);
      n_vec++; if (state !== 3'd0 || target !== 4'd2) begin n_err++;
         $display("FAIL set_quit: got state=%0d target=%0d want 0/2", state, target); end
      press(P_C);
      n_vec++; if (state !== 3'd1 || target !== 4'd3) begin n_err++;
         $display("FAIL set_reload: got state=%0d target=%0d want 1/3", state, target); end
   endtask

   task automatic test_game;
      press(P_C);
      n_vec++; if (state !== 3'd2) begin n_err++; $display("FAIL start_state: got %0d want 2", state); end
      point(1, 0);
      n_vec++; if (score_p1 !== 4'd0 || state !== 3'd2) begin n_err++;
         $display("FAIL start_point_ignored: got p1=%0d state=%0d want 0/2", score_p1, state); end
      serve_cnt = 0;
      press(P_C);
      n_vec++; if (state !== 3'd3) begin n_err++; $display("FAIL play_state: got %0d want 3", state); end
      n_vec++; if (serve_cnt !== 1) begin n_err++; $display("FAIL serve_once: got %0d want 1", serve_cnt); end
      for (int k = 1; k <= 3; k++) begin
         point(1, 0);
         n_vec++; if (state !== 3'd4 || score_p1 !== 4'(k)) begin n_err++;
            $display("FAIL point_p1_%0d: got state=%0d p1=%0d want 4/%0d", k, state, score_p1, k); end
         tick(7);
         n_vec++; if (state !== 3'd4) begin n_err++; $display("FAIL hold_%0d: got %0d want 4", k, state); end
         tick(1);
         if (k < 3) begin
            n_vec++; if (state !== 3'd2) begin n_err++; $display("FAIL hold_exit_%0d: got %0d want 2", k, state); end
            press(P_C);
         end else begin
            n_vec++; if (state !== 3'd5 || winner !== 2'b01) begin n_err++;
               $display("FAIL game_won: got state=%0d winner=%0d want 5/1", state, winner); end
            n_vec++; if (led !== 6'b100000) begin n_err++; $display("FAIL end_led: got %b want 100000", led); end
         end
      end
      press(P_C);
      n_vec++; if (state !== 3'd0 || score_p1 !== 4'd3 || winner !== 2'b01) begin n_err++;
         $display("FAIL end_to_menu: got state=%0d p1=%0d w=%0d want 0/3/1", state, score_p1, winner); end
   endtask

   task automatic test_tie;
      press(P_C);
      press(P_C);
      n_vec++; if (state !== 3'd2 || score_p1 !== 4'd0 || winner !== 2'b00) begin n_err++;
         $display("FAIL new_game_clear: got state=%0d p1=%0d w=%0d want 2/0/0", state, score_p1, winner); end
      press(P_C);
      point(1, 1);
      n_vec++; if (state !== 3'd4 || score_p1 !== 4'd0 || score_p2 !== 4'd0) begin n_err++;
         $display("FAIL tie_point: got state=%0d p1=%0d p2=%0d want 4/0/0", state, score_p1, score_p2); end
      tick(8);
      n_vec++; if (state !== 3'd2) begin n_err++; $display("FAIL tie_exit: got %0d want 2", state); end
   endtask

   task automatic test_quit;
      press(P_C); point(1, 0); tick(8);
      press(P_C); point(1, 0); tick(8);
      press(P_C); point(0, 1); tick(8);
      press(P_C);
      n_vec++; if (state !== 3'd3 || score_p1 !== 4'd2 || score_p2 !== 4'd1) begin n_err++;
         $display("FAIL score_2_1: got state=%0d p1=%0d p2=%0d want 3/2/1", state, score_p1, score_p2); end
      press(P_L);
      n_vec++; if (state !== 3'd0 || score_p1 !== 4'd0 || score_p2 !== 4'd0 || target !== 4'd3) begin n_err++;
         $display("FAIL play_quit: got state=%0d p1=%0d p2=%0d t=%0d want 0/0/0/3", state, score_p1, score_p2, target); end
   endtask

   task automatic test_reset_mid;
      press(P_C); press(P_U); press(P_C); press(P_C);
      point(0, 1);
      n_vec++; if (state !== 3'd4 || score_p2 !== 4'd1 || target !== 4'd4) begin n_err++;
         $display("FAIL pre_reset: got state=%0d p2=%0d t=%0d want 4/1/4", state, score_p2, target); end
      rst = 1;
      tick(1);
      rst = 0;
      n_vec++; if (state !== 3'd0 || led !== 6'b000001) begin n_err++;
         $display("FAIL mid_reset_state: got state=%0d led=%b want 0/000001", state, led); end
      n_vec++; if (score_p1 !== 4'd0 || score_p2 !== 4'd0 || target !== 4'd3 || winner !== 2'b00 || serve !== 1'b0) begin n_err++;
         $display("FAIL mid_reset_regs: got p1=%0d p2=%0d t=%0d w=%0d s=%0d want 0/0/3/0/0",
                  score_p1, score_p2, target, winner, serve); end
   endtask

   initial begin
      test_reset;
      test_bounce;
      test_target;
      test_game;
      test_tie;
      test_quit;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
